// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, ALU control
// source codes, datapath mux encodings, state encoding and the control word.
package multicycle_control_pkg;

    // Opcodes (IR[15:12]); anything not listed executes as a NOP.
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_LW    = 4'd1;
    localparam logic [3:0] OP_SW    = 4'd2;
    localparam logic [3:0] OP_ADDI  = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_J     = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // ALU control source codes consumed by the ALU control decoder.
    localparam logic [2:0] OPSC_ADD   = 3'b000;
    localparam logic [2:0] OPSC_SUB   = 3'b011;
    localparam logic [2:0] OPSC_FUNCT = 3'b100;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_OFFSET = 2'b11;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states, 4-bit, FETCH encoded as zero.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_R_WB     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_IMM_EXEC = 4'd8,
        S_IMM_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    // Every datapath control driven by the controller, in one bundle.
    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] opsc;
        logic       halted;
    } ctl_word_t;

    // Dispatch target leaving DECODE for a given opcode.
    function automatic state_e dispatch(input logic [3:0] opcode);
        case (opcode)
            OP_RTYPE:     return S_R_EXEC;
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_ADDI:      return S_IMM_EXEC;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            OP_HALT:      return S_HALT;
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller; the slave side is the datapath and memory.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [2:0]       opsc;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               opsc, halted, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               opsc, halted, instr_count
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational control-word decoder: current state plus the two Mealy
// inputs (mem_ready in FETCH, zero in BRANCH) to every datapath control.
module control_word_decode
    import multicycle_control_pkg::*;
(
    input  state_e    state_i,
    input  logic      mem_ready_i,
    input  logic      zero_i,
    output ctl_word_t ctl_o
);

    logic pc_write;
    logic pc_write_cond;

    // Decode the control word for the current state; pc_en folds in the branch condition.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        ctl_o         = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state_i)
            S_FETCH: begin
                ctl_o.mem_read  = 1'b1;
                ctl_o.alu_src_b = SRCB_ONE;
                ctl_o.opsc      = OPSC_ADD;
                ctl_o.pc_source = PCSRC_ALU;
                // IR and PC only load once the instruction word has arrived.
                ctl_o.ir_write  = mem_ready_i;
                pc_write        = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ctl_o.alu_src_b = SRCB_OFFSET;
                ctl_o.opsc      = OPSC_ADD;
            end
            S_R_EXEC: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_REGB;
                ctl_o.opsc      = OPSC_FUNCT;
            end
            S_R_WB: begin
                ctl_o.reg_dst   = 1'b1;
                ctl_o.reg_write = 1'b1;
            end
            S_MEM_ADDR, S_IMM_EXEC: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_IMM;
                ctl_o.opsc      = OPSC_ADD;
            end
            S_MEM_RD: begin
                ctl_o.mem_read = 1'b1;
                ctl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl_o.mem_to_reg = 1'b1;
                ctl_o.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctl_o.mem_write = 1'b1;
                ctl_o.iord      = 1'b1;
            end
            S_IMM_WB: begin
                ctl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_REGB;
                ctl_o.opsc      = OPSC_SUB;
                ctl_o.pc_source = PCSRC_ALUOUT;
                pc_write_cond   = 1'b1;
            end
            S_JUMP: begin
                ctl_o.pc_source = PCSRC_JUMP;
                pc_write        = 1'b1;
            end
            S_HALT: begin
                ctl_o.halted = 1'b1;
            end
            default: begin
            end
        endcase
        ctl_o.pc_en = pc_write | (pc_write_cond & zero_i);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: state register, next-state logic and the
// retired-instruction counter. Control decoding lives in control_word_decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_control_if.master bus
);

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    ctl_word_t        ctl;
    ctl_word_t        ctl_out;

    // State, store flag and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE, so LW vs SW is
    // captured there for the MEM_ADDR branch.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d    = dispatch(bus.opcode);
                is_store_d = (bus.opcode == OP_SW);
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_IMM_EXEC: state_d = S_IMM_WB;
            S_R_WB, S_MEM_WB, S_IMM_WB, S_BRANCH, S_JUMP:
                        state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires whenever control returns to FETCH from elsewhere.
    always_comb begin
        retire  = (state_q != S_FETCH) && (state_d == S_FETCH);
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    control_word_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .zero_i      (bus.zero),
        .ctl_o       (ctl)
    );

    // Reset forces every output low, including the Mealy FETCH terms.
    always_comb begin
        ctl_out = rst ? '0 : ctl;
    end

    assign bus.pc_en       = ctl_out.pc_en;
    assign bus.iord        = ctl_out.iord;
    assign bus.mem_read    = ctl_out.mem_read;
    assign bus.mem_write   = ctl_out.mem_write;
    assign bus.ir_write    = ctl_out.ir_write;
    assign bus.reg_dst     = ctl_out.reg_dst;
    assign bus.mem_to_reg  = ctl_out.mem_to_reg;
    assign bus.reg_write   = ctl_out.reg_write;
    assign bus.alu_src_a   = ctl_out.alu_src_a;
    assign bus.alu_src_b   = ctl_out.alu_src_b;
    assign bus.pc_source   = ctl_out.pc_source;
    assign bus.opsc        = ctl_out.opsc;
    assign bus.halted      = ctl_out.halted;
    assign bus.instr_count = rst ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Two controllers (16-bit and
// 4-bit counters) share the same stimulus. Each instruction is expanded into
// its per-cycle expected control words from the opcode's action table; the
// driver queues them and a negedge monitor compares both DUTs cycle by cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(16)) bus16 ();
    multicycle_control_if #(.CNT_W(4))  bus4 ();

    assign bus16.opcode    = opcode;
    assign bus16.zero      = zero;
    assign bus16.mem_ready = mem_ready;
    assign bus4.opcode     = opcode;
    assign bus4.zero       = zero;
    assign bus4.mem_ready  = mem_ready;

    multicycle_control #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    multicycle_control #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] opsc;
        logic       halted;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [15:0] count;
    } exp_t;

    // One planned cycle: expected controls and how to drive the inputs.
    typedef struct packed {
        ctl_t ctl;
        logic rdy_care;
        logic rdy;
        logic is_decode;
        logic is_branch;
    } plan_t;

    exp_t        exp_q[$];
    plan_t       plan_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int unsigned model_count = 0;

    ctl_t act16, act4;
    assign act16 = {bus16.pc_en, bus16.iord, bus16.mem_read, bus16.mem_write,
                    bus16.ir_write, bus16.reg_dst, bus16.mem_to_reg,
                    bus16.reg_write, bus16.alu_src_a, bus16.alu_src_b,
                    bus16.pc_source, bus16.opsc, bus16.halted};
    assign act4  = {bus4.pc_en, bus4.iord, bus4.mem_read, bus4.mem_write,
                    bus4.ir_write, bus4.reg_dst, bus4.mem_to_reg,
                    bus4.reg_write, bus4.alu_src_a, bus4.alu_src_b,
                    bus4.pc_source, bus4.opsc, bus4.halted};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    // Expected control words, straight from the per-state action table.
    function automatic ctl_t w_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy;
        return c;
    endfunction
    function automatic ctl_t w_decode();
        ctl_t c = '0;
        c.alu_src_b = 2'b11;
        return c;
    endfunction
    function automatic ctl_t w_exec(input logic [1:0] b, input logic [2:0] sc);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = b; c.opsc = sc;
        return c;
    endfunction
    function automatic ctl_t w_wb(input logic dst, input logic m2r);
        ctl_t c = '0;
        c.reg_dst = dst; c.mem_to_reg = m2r; c.reg_write = 1'b1;
        return c;
    endfunction
    function automatic ctl_t w_mem(input logic wr);
        ctl_t c = '0;
        c.iord = 1'b1; c.mem_write = wr; c.mem_read = ~wr;
        return c;
    endfunction
    function automatic ctl_t w_branch(input logic z);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.opsc = 3'b011; c.pc_source = 2'b01; c.pc_en = z;
        return c;
    endfunction
    function automatic ctl_t w_jump();
        ctl_t c = '0;
        c.pc_en = 1'b1; c.pc_source = 2'b10;
        return c;
    endfunction
    function automatic ctl_t w_halt();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    task automatic plan(input ctl_t c, input logic care, input logic rdy,
                        input logic dec, input logic br);
        plan_q.push_back({c, care, rdy, dec, br});
    endtask

    // Drive one cycle and queue what both DUTs must show during it.
    task automatic step(input ctl_t c, input logic mr, input logic z, input logic [3:0] op);
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        exp_q.push_back({c, 16'(model_count)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic rdy);
        rst = 1'b1;
        model_count = 0;
        for (int i = 0; i < n; i++) step('0, rdy, rbit(), rop());
        rst = 1'b0;
    endtask

    // fs / ms: cycles of mem_ready low in FETCH / in the memory access state.
    // For HALT, ms is how many halted cycles to observe. abort_at > 0 stops
    // after that many cycles (a reset is expected to follow).
    task automatic run_instr(input logic [3:0] op, input int fs, input int ms,
                             input logic z, input int abort_at);
        int n;
        for (int i = 0; i < fs; i++) plan(w_fetch(1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
        plan(w_fetch(1'b1), 1'b1, 1'b1, 1'b0, 1'b0);
        plan(w_decode(), 1'b0, 1'b0, 1'b1, 1'b0);
        case (op)
            4'd0: begin
                plan(w_exec(2'b00, 3'b100), 1'b0, 1'b0, 1'b0, 1'b0);
                plan(w_wb(1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            4'd1, 4'd2: begin
                plan(w_exec(2'b10, 3'b000), 1'b0, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < ms; i++) plan(w_mem(op == 4'd2), 1'b1, 1'b0, 1'b0, 1'b0);
                plan(w_mem(op == 4'd2), 1'b1, 1'b1, 1'b0, 1'b0);
                if (op == 4'd1) plan(w_wb(1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            4'd3: begin
                plan(w_exec(2'b10, 3'b000), 1'b0, 1'b0, 1'b0, 1'b0);
                plan(w_wb(1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            4'd4: plan(w_branch(z), 1'b0, 1'b0, 1'b0, 1'b1);
            4'd5: plan(w_jump(), 1'b0, 1'b0, 1'b0, 1'b0);
            4'd15: for (int i = 0; i < ms; i++) plan(w_halt(), 1'b0, 1'b0, 1'b0, 1'b0);
            default: begin
            end
        endcase
        n = (abort_at > 0) ? abort_at : plan_q.size();
        for (int i = 0; i < n; i++) begin
            plan_t p = plan_q[i];
            step(p.ctl, p.rdy_care ? p.rdy : rbit(), p.is_branch ? z : rbit(),
                 p.is_decode ? op : rop());
        end
        plan_q.delete();
        if (abort_at == 0 && op != 4'd15) model_count++;
    endtask

    // Monitor: compares both DUTs against the queued expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("ctl16@%0d", cyc), 32'(act16), 32'(e.ctl));
            check($sformatf("count16@%0d", cyc), 32'(bus16.instr_count), 32'(e.count));
            check($sformatf("ctl4@%0d", cyc), 32'(act4), 32'(e.ctl));
            check($sformatf("count4@%0d", cyc), 32'(bus4.instr_count), 32'(e.count[3:0]));
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        opcode    = 4'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with mem_ready high: Mealy terms must stay low.
        do_reset(2, 1'b1);

        // R-type then LW, no stalls.
        run_instr(4'd0, 0, 0, 1'b0, 0);
        run_instr(4'd1, 0, 0, 1'b0, 0);

        // SW with 3 FETCH stalls and 2 MEM_WR stalls (9 cycles).
        run_instr(4'd2, 3, 2, 1'b0, 0);

        // BEQ taken and not taken.
        run_instr(4'd4, 0, 0, 1'b1, 0);
        run_instr(4'd4, 0, 0, 1'b0, 0);

        // Illegal opcode: NOP, still counted.
        run_instr(4'd7, 0, 0, 1'b0, 0);

        // Random instruction mix (no HALT) with random stalls.
        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(0, 14)), $urandom_range(0, 3),
                      $urandom_range(0, 3), rbit(), 0);
        end

        // Reset in the middle of an LW aborts it with no count.
        run_instr(4'd1, 1, 0, 1'b0, 3);
        do_reset(1, rbit());

        // 16 jumps: the 4-bit counter wraps back to zero.
        for (int i = 0; i < 16; i++) run_instr(4'd5, 0, 0, 1'b0, 0);
        check("wrap4", 32'(bus4.instr_count), 32'd0);
        check("count16_after_jumps", 32'(bus16.instr_count), 32'd16);

        // HALT is sticky for 50 cycles with the count frozen.
        run_instr(4'd15, 0, 50, 1'b0, 0);

        // Reset out of HALT, then one more instruction from a zero count.
        do_reset(1, 1'b1);
        run_instr(4'd3, 1, 0, 1'b0, 0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
